// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings, LED patterns and helpers for the LED pattern engine.
package led_ctrl_pkg;

    localparam int unsigned LED_W = 4;

    localparam logic [1:0] MODE_RUN    = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_BREATH = 2'd2;
    localparam logic [1:0] MODE_ALL_ON = 2'd3;

    localparam logic [LED_W-1:0] PAT_RUN_INIT = 4'b0001;
    localparam logic [LED_W-1:0] PAT_ALL      = 4'b1111;
    localparam logic [LED_W-1:0] PAT_OFF      = 4'b0000;

    typedef enum logic [1:0] {
        ST_RUN    = MODE_RUN,
        ST_BLINK  = MODE_BLINK,
        ST_BREATH = MODE_BREATH,
        ST_ALL_ON = MODE_ALL_ON
    } mode_e;

    // Rotate a running-light pattern one position to the left.
    function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] p);
        return {p[LED_W-2:0], p[LED_W-1]};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer, tick-based debouncer and press detector.
module key_debounce #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);

    logic             sync_meta;
    logic             sync_key;
    logic             stable_key;
    logic [CNT_W-1:0] db_cnt;
    logic             accept_c;

    // New level is accepted on the tick that completes the stability window.
    assign accept_c = tick && (sync_key != stable_key) &&
                      (db_cnt == CNT_W'(DEBOUNCE_MS - 1));

    // Press is flagged in the accepting tick cycle so it can coincide with a pattern step.
    assign press = accept_c && !sync_key;

    // Two-flop synchronizer; idles at released level.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync_key  <= sync_meta;
        end
    end

    // Stability counter and debounced level.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stable_key <= 1'b1;
            db_cnt     <= '0;
        end else if (sync_key == stable_key) begin
            db_cnt <= '0;
        end else if (tick) begin
            if (accept_c) begin
                stable_key <= sync_key;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pattern engine: ms prescaler, button-driven mode FSM, step timer and pattern/PWM generation.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 200_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned STEP_MS     = 250,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned PWM_BITS    = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             key_n,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             tick_ms
);

    localparam int unsigned PRE_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int unsigned PRE_W   = $clog2(PRE_MAX + 1);
    localparam int unsigned STEP_W  = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PRE_W-1:0]    pre_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                step_c;
    logic                press;
    mode_e               mode_q;
    mode_e               mode_d;
    logic [LED_W-1:0]    init_pat_c;
    logic [LED_W-1:0]    pattern;
    logic                started;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                dir_up;

    key_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_key_debounce (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (tick_ms),
        .key_n   (key_n),
        .press   (press)
    );

    // Millisecond prescaler; tick follows the cycle where the counter wraps.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pre_cnt <= '0;
            tick_ms <= 1'b0;
        end else begin
            tick_ms <= (pre_cnt == PRE_W'(PRE_MAX));
            pre_cnt <= (pre_cnt == PRE_W'(PRE_MAX)) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    assign step_c = tick_ms && (step_cnt == STEP_W'(STEP_MS - 1));

    // Step counter; a press restarts the step period and swallows a coincident step.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (press) begin
            step_cnt <= '0;
        end else if (tick_ms) begin
            step_cnt <= step_c ? '0 : step_cnt + STEP_W'(1);
        end
    end

    // Mode state register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode_q <= ST_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode advance on press and the pattern the new mode starts from.
    always_comb begin
        mode_d     = mode_q;
        init_pat_c = PAT_RUN_INIT;
        if (press) begin
            case (mode_q)
                ST_RUN:    mode_d = ST_BLINK;
                ST_BLINK:  mode_d = ST_BREATH;
                ST_BREATH: mode_d = ST_ALL_ON;
                default:   mode_d = ST_RUN;
            endcase
        end
        case (mode_d)
            ST_BLINK, ST_ALL_ON: init_pat_c = PAT_ALL;
            ST_BREATH:           init_pat_c = PAT_OFF;
            default:             init_pat_c = PAT_RUN_INIT;
        endcase
    end

    assign mode = 2'(mode_q);

    // Pattern generation, breathing duty ramp and LED output register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pattern <= PAT_OFF;
            started <= 1'b0;
            pwm_cnt <= '0;
            duty    <= '0;
            dir_up  <= 1'b1;
            led     <= PAT_OFF;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            led     <= pattern;
            started <= 1'b1;
            if (!started) begin
                pattern <= PAT_RUN_INIT;
            end else if (press) begin
                pattern <= init_pat_c;
                duty    <= '0;
                dir_up  <= 1'b1;
            end else begin
                case (mode_q)
                    ST_RUN: begin
                        if (step_c) pattern <= rotl1(pattern);
                    end
                    ST_BLINK: begin
                        if (step_c) pattern <= ~pattern;
                    end
                    ST_BREATH: begin
                        pattern <= {LED_W{pwm_cnt < duty}};
                        if (tick_ms) begin
                            if (dir_up) begin
                                if (duty == DUTY_MAX) begin
                                    dir_up <= 1'b0;
                                    duty   <= duty - PWM_BITS'(1);
                                end else begin
                                    duty <= duty + PWM_BITS'(1);
                                end
                            end else begin
                                if (duty == '0) begin
                                    dir_up <= 1'b1;
                                    duty   <= PWM_BITS'(1);
                                end else begin
                                    duty <= duty - PWM_BITS'(1);
                                end
                            end
                        end
                    end
                    ST_ALL_ON: begin
                        pattern <= PAT_ALL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl at 10 clk/tick, 4 ticks/step, 3-tick debounce, 4-bit PWM.
module tb_led_mode_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick_ms;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          cyc     = 0;

    led_mode_ctrl #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100),
        .STEP_MS     (4),
        .DEBOUNCE_MS (3),
        .PWM_BITS    (4)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .key_n   (key_n),
        .led     (led),
        .mode    (mode),
        .tick_ms (tick_ms)
    );

    always #5 sys_clk = ~sys_clk;

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; cyc counts edges since reset release.
    task automatic clk1();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) clk1();
    endtask

    // Key waveform: bouncy press from 360, held low, bouncy release from 440.
    function automatic logic bounce_key(input int c);
        if (c < 378)      return ((c - 360) / 3) % 2 == 1;
        else if (c < 440) return 1'b0;
        else if (c < 458) return ((c - 440) / 3) % 2 == 0;
        else              return 1'b1;
    endfunction

    // Breathing duty during cycle c, with BREATH entered at edge 401.
    function automatic int duty_at(input int c);
        int n;
        if (c < 401) return 0;
        n = ((c - 401) / 10) % 30;
        return (n <= 15) ? n : 30 - n;
    endfunction

    // Press after the previous release settles; m is the first cycle showing the new mode.
    task automatic press_key(input string tag, input logic [1:0] exp_mode, output int m);
        logic [1:0] prev;
        repeat (60) clk1();
        prev  = mode;
        key_n = 1'b0;
        m     = -1;
        for (int i = 0; i < 100; i++) begin
            clk1();
            if (mode != prev) begin
                m = cyc;
                break;
            end
        end
        key_n = 1'b1;
        check(tag, 32'(mode), 32'(exp_mode));
        if (m < 0) m = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int p;
        int e;

        // Reset state
        rst   = 1'b1;
        key_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk);
            #1;
            check("rst_led", 32'(led), 0);
            check("rst_mode", 32'(mode), 0);
            check("rst_tick", 32'(tick_ms), 0);
        end
        rst = 1'b0;
        cyc = 0;

        // First pattern load and tick cadence
        for (int i = 1; i <= 20; i++) begin
            clk1();
            check("tick_ms", 32'(tick_ms), (i % 10 == 0) ? 1 : 0);
            if (i == 1) check("led_first_clk", 32'(led), 0);
            if (i == 2) check("led_second_clk", 32'(led), 1);
        end

        // RUN rotation every 40 clocks
        for (int k = 0; k < 5; k++) begin
            run_to(40 * k + 41);
            check("run_hold", 32'(led), 32'(1) << (k % 4));
            clk1();
            check("run_rot", 32'(led), 32'(1) << ((k + 1) % 4));
        end

        // Short press (2 ticks) is rejected
        run_to(205);
        key_n = 1'b0;
        run_to(225);
        key_n = 1'b1;
        run_to(240);
        check("short_press_mode", 32'(mode), 0);

        // Clean 50-clock press
        run_to(245);
        key_n = 1'b0;
        run_to(270);
        check("press_pre_mode", 32'(mode), 0);
        clk1();
        check("press_mode", 32'(mode), 1);
        clk1();
        check("blink_init", 32'(led), 15);
        run_to(295);
        key_n = 1'b1;
        run_to(311);
        check("blink_hold", 32'(led), 15);
        clk1();
        check("blink_off", 32'(led), 0);
        run_to(352);
        check("blink_on", 32'(led), 15);

        // Bouncy press into BREATH, then breathing waveform over 32 ticks
        run_to(360);
        key_n = bounce_key(360);
        for (int c = 361; c <= 722; c++) begin
            clk1();
            if (c == 400) check("bounce_hold", 32'(mode), 1);
            if (c == 401) check("bounce_press", 32'(mode), 2);
            if (c >= 402) begin
                p = c - 2;
                e = ((p % 16) < duty_at(p)) ? 15 : 0;
                check("breath_led", 32'(led), 32'(e));
            end
            key_n = bounce_key(c);
        end
        check("bounce_single", 32'(mode), 2);

        // ALL_ON ignores steps
        press_key("to_allon", 2'd3, m);
        clk1();
        check("allon_led", 32'(led), 15);
        run_to(m + 50);
        check("allon_hold", 32'(led), 15);

        // Re-entry to RUN restarts the pattern and step period
        press_key("to_run", 2'd0, m);
        clk1();
        check("run_reentry", 32'(led), 1);
        run_to(m + 40);
        check("run_restart_hold", 32'(led), 1);
        clk1();
        check("run_restart_rot", 32'(led), 2);

        // Full wrap from RUN
        press_key("wrap_blink", 2'd1, m);
        press_key("wrap_breath", 2'd2, m);
        press_key("wrap_allon", 2'd3, m);
        press_key("wrap_run", 2'd0, m);
        clk1();
        check("wrap_led", 32'(led), 1);
        run_to(m + 40);
        check("wrap_hold", 32'(led), 1);
        clk1();
        check("wrap_rot", 32'(led), 2);

        // Press accepted on the same tick as a step
        run_to(m + 51);
        key_n = 1'b0;
        run_to(m + 79);
        check("coll_tick", 32'(tick_ms), 1);
        check("coll_pre_mode", 32'(mode), 0);
        clk1();
        check("coll_mode", 32'(mode), 1);
        check("coll_norot", 32'(led), 2);
        clk1();
        check("coll_blink", 32'(led), 15);
        key_n = 1'b1;
        run_to(m + 120);
        check("coll_blink_hold", 32'(led), 15);
        clk1();
        check("coll_blink_step", 32'(led), 0);

        // Reset in BLINK with a debounce in progress
        key_n = 1'b0;
        run_to(m + 145);
        rst = 1'b1;
        clk1();
        check("rst_mid_led", 32'(led), 0);
        check("rst_mid_mode", 32'(mode), 0);
        check("rst_mid_tick", 32'(tick_ms), 0);
        clk1();
        rst = 1'b0;
        cyc = 0;
        clk1();
        clk1();
        check("rst_mid_pat", 32'(led), 1);
        run_to(30);
        check("rst_mid_db_cleared", 32'(mode), 0);
        clk1();
        check("rst_mid_db_press", 32'(mode), 1);
        key_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
